alu_sequencer: RTL and testbench
================================

# alu_sequencer

Micro-sequencer that owns the 8-bit ALU's `opcode`/`A`/`B` inputs and steps it through a short stored program. Each program word is issued one instruction at a time, the registered ALU output is captured, and completion is signalled with a start/busy/done handshake. Results can be chained, so the previous captured result feeds operand A. It sits between the ALU and whatever host loads and launches programs, and it is the only driver of the ALU inputs.

## Interface
- `DEPTH`, 16: program words; the address width is fixed at 4 bits, so DEPTH ≤ 16.
- `ALU_LAT`, 1: clock edges from the ALU sampling its inputs until `ALU_Out` is valid; range 1..7.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `prog_we`  in  1  program-memory write strobe.
- `prog_addr`  in  4  program-memory write address.
- `prog_data`  in  21  instruction: {use_prev[20], opcode[19:16], a_imm[15:8], b_imm[7:0]}.
- `start`  in  1  launch request, sampled in IDLE only.
- `len`  in  5  instruction count, 0..DEPTH, latched on accepted start.
- `alu_out`  in  8  ALU result, wired from the ALU `ALU_Out`.
- `alu_opcode`  out  4  to the ALU `opcode`.
- `alu_a`  out  8  to the ALU `A`.
- `alu_b`  out  8  to the ALU `B`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  8  last captured ALU result.
- `pc`  out  4  index of the instruction in flight.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE; binary encoded.
- **IDLE:**
  - `start`=1 and `len`≠0: latch `len`, set `pc`=0, go to ISSUE.
  - `start`=1 and `len`=0: go straight to DONE; `result` is unchanged.
- **ISSUE (1 cycle):**
  - Register `alu_opcode`/`alu_b` from `mem[pc]`.
  - `alu_a` = `result` if use_prev=1, else a_imm.
  - Load the wait counter with `ALU_LAT`, go to WAIT.
- **WAIT (`ALU_LAT` cycles):**
  - Decrement the counter each cycle.
  - On the final WAIT cycle's edge, `result` ← `alu_out`.
  - If `pc` = len−1, go to DONE; else `pc` ← `pc`+1 and go to ISSUE.
- **DONE (1 cycle):** `done`=1, then go to IDLE.
- **ALU input hold:** `alu_opcode`/`alu_a`/`alu_b` are registered and keep their last issued values until the next ISSUE; no glitching.
- **Program writes:** `prog_we` writes `mem[prog_addr]` only in IDLE. Writes are ignored while busy, and writes with `prog_addr` ≥ DEPTH are ignored.
- **Start while busy:** `start` in a non-IDLE state is ignored; there is no queuing.
- **Oversize length:** `len` > DEPTH is clamped to DEPTH at latch time.
- **Chaining:** use_prev on the first instruction uses `result` from the previous run, or 0 after reset.
- **Width:** no arithmetic on data. `pc` uses a 4-bit compare against the latched `len`−1; there is no wrap because `len` ≤ 16.

## Timing
- **Reset values (async on `rst_n` low):** state=IDLE, `pc`=0, `result`=0, `alu_opcode`/`alu_a`/`alu_b`=0, `busy`=0, `done`=0, all program words=0.
- **Reset mid-run:** abort immediately to IDLE with the values above; no `done` pulse. The ALU is left with zero inputs.
- **Launch:** `start` is sampled at edge t0; ISSUE is the cycle after t0, and `busy` rises after t0.
- **Per-instruction cost:** 1+`ALU_LAT` cycles.
- **Completion:** `done` is high for the one cycle following edge t0 + N·(1+`ALU_LAT`), then `busy` falls at the next edge.
- **Zero-length run:** `len`=0 gives `done` in the cycle after t0, and `busy` is high for that cycle only.
- **Result visibility:** `result` is valid from the same edge that enters DONE and holds until the next capture or reset.
- **Back-to-back runs:** `start` held high across a DONE cycle is accepted on the IDLE cycle that follows. The minimum gap is 1 IDLE cycle between runs.

## Test plan
The bench uses a stub ALU that registers `ALU_Out` = A+B for opcode 0000 and A−B for opcode 0001, with `ALU_LAT`=1.

1. **Reset:** assert `rst_n`=0 mid-clock → all outputs 0 asynchronously, before the next edge.
2. **Single instruction:** load {0,0000,0x01,0x01}, pulse start with `len`=1 → `alu_a`=1, `alu_b`=1 in ISSUE; `done` after edge t0+2; `result`=0x02.
3. **Chained three-step program:** {0,0000,0x05,0x03}, {1,0000,x,0x0A}, {1,0001,x,0x04}, `len`=3 → results 0x08, 0x12, 0x0E; `done` after edge t0+6; `pc` sequence 0,1,2.
4. **Zero length and wrap:** `len`=0 → `done` the cycle after start, `result` unchanged. A chained 0xFF+0x01 → `result`=0x00, with no flags expected.
5. **Protocol abuse:**
   - `start` and `prog_we` asserted during the run → ignored.
   - `mem` contents unchanged afterwards.
   - Exactly one `done` pulse.
6. **Reset mid-WAIT then relaunch:** drop `rst_n` in WAIT of instruction 2 → no `done`, state IDLE. The relaunch after reset runs from `pc`=0 with `mem` cleared, giving `result`=0x00.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Host/ALU-facing bundle of the ALU micro-sequencer: program load, launch handshake, ALU drive and status.
// Latency: none, this is wiring only.
// Backpressure: none; start is only honoured while the sequencer is idle, and the host watches busy/done.
//
// Signals:
//   prog_we/prog_addr/prog_data : program-memory write port (host -> sequencer)
//   start/len                   : launch request and instruction count (host -> sequencer)
//   alu_out                     : registered ALU result (ALU -> sequencer)
//   alu_opcode/alu_a/alu_b      : ALU operands (sequencer -> ALU)
//   busy/done/result/pc         : run status (sequencer -> host)
interface alu_sequencer_if;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [20:0] prog_data;
    logic        start;
    logic [4:0]  len;
    logic [7:0]  alu_out;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        busy;
    logic        done;
    logic [7:0]  result;
    logic [3:0]  pc;

    // Host plus ALU side: drives the requests and the ALU result, observes everything else.
    modport master (
        output prog_we, prog_addr, prog_data, start, len, alu_out,
        input  alu_opcode, alu_a, alu_b, busy, done, result, pc
    );

    // Sequencer side.
    modport slave (
        input  prog_we, prog_addr, prog_data, start, len, alu_out,
        output alu_opcode, alu_a, alu_b, busy, done, result, pc
    );
endinterface

// File: rtl/alu_sequencer.sv
// Steps an 8-bit ALU through a stored program of up to DEPTH words, chaining results into operand A on request.
// Latency: 1 + ALU_LAT cycles per instruction; done pulses the cycle after the last capture; len=0 completes in 1 cycle.
// Backpressure: start and program writes are ignored while busy, so there is no queueing; the host waits for done.
//
// Ports:
//   clk, rst_n : sole clock and asynchronous active-low reset
//   bus        : alu_sequencer_if.slave, carrying program writes, start/len, the ALU operands and result, and busy/done/result/pc
//
// Instruction word layout: {use_prev[20], opcode[19:16], a_imm[15:8], b_imm[7:0]}.
module alu_sequencer #(
    parameter int DEPTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);

    typedef struct packed {
        logic       use_prev;
        logic [3:0] opcode;
        logic [7:0] a_imm;
        logic [7:0] b_imm;
    } instr_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);
    localparam logic [4:0] DEPTH_W  = 5'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    instr_t     mem_q [DEPTH];
    state_t     state_q;
    logic [3:0] pc_q;
    logic [3:0] last_q;      // index of the final instruction, i.e. clamped len - 1
    logic [2:0] cnt_q;       // remaining WAIT cycles for the instruction in flight
    logic [7:0] result_q;
    logic [3:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       busy_q;
    logic       done_q;

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic [4:0] len_clamp_d;
    logic [3:0] last_d;
    logic [3:0] pc_inc_d;
    instr_t     first_d;
    instr_t     next_d;
    logic       mem_we_d;

    always_comb begin
        len_clamp_d = (bus.len > DEPTH_W) ? DEPTH_W : bus.len;
        // Only used when len is non-zero, so the subtraction never underflows.
        last_d      = 4'(len_clamp_d - 5'd1);
        pc_inc_d    = pc_q + 4'd1;
        first_d     = mem_q[0];
        // pc+1 only matters when pc is not the last instruction, so it stays below DEPTH.
        next_d      = mem_q[pc_inc_d];
        mem_we_d    = (state_q == S_IDLE) && bus.prog_we &&
                      ({1'b0, bus.prog_addr} < DEPTH_W);
    end

    // ------------------------------------------------------------------
    // Program memory: writable only while idle, cleared by reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we_d) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    //
    // The ALU operand registers are loaded on the edge that enters ISSUE,
    // so they are stable for the whole ISSUE cycle and the ALU samples
    // them on the edge that leaves ISSUE. After ALU_LAT WAIT cycles the
    // result is captured on the final WAIT edge. When that same edge
    // issues the next chained instruction, the freshly captured value
    // has to come straight from alu_out because result_q is only being
    // written on that edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.len == 5'd0) begin
                            // Empty program: report completion without touching result.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            pc_q    <= 4'd0;
                            last_q  <= last_d;
                            op_q    <= first_d.opcode;
                            b_q     <= first_d.b_imm;
                            a_q     <= first_d.use_prev ? result_q : first_d.a_imm;
                        end
                    end
                end

                S_ISSUE: begin
                    cnt_q   <= LAT_LOAD;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (cnt_q == 3'd1) begin
                        result_q <= bus.alu_out;
                        if (pc_q == last_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            pc_q    <= pc_inc_d;
                            op_q    <= next_d.opcode;
                            b_q     <= next_d.b_imm;
                            a_q     <= next_d.use_prev ? bus.alu_out : next_d.a_imm;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.alu_opcode = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.pc         = pc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a stub ALU (opcode 0: A+B, opcode 1: A-B, one-cycle registered).
// Expected run results are queued at launch and compared when done pulses; issue timing is checked per cycle.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there or on the falling edge.
module tb_alu_sequencer;
    localparam int LAT   = 1;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_sequencer_if bus ();

    alu_sequencer #(.DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stub ALU, registered output.
    always @(posedge clk) begin
        case (bus.alu_opcode)
            4'd0:    bus.alu_out <= bus.alu_a + bus.alu_b;
            4'd1:    bus.alu_out <= bus.alu_a - bus.alu_b;
            default: bus.alu_out <= 8'h00;
        endcase
    end

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [20:0] tb_mem [DEPTH];
    logic [7:0]  m_result;
    logic [7:0]  exp_a  [DEPTH];
    logic [7:0]  exp_b  [DEPTH];
    logic [3:0]  exp_op [DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                check_eq("run_result", 32'(bus.result), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [20:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr[3:0];
        bus.prog_data = d;
        tick();
        bus.prog_we   = 1'b0;
        tb_mem[addr]  = d;
    endtask

    // Launch a run of n instructions and follow it to completion.
    // abuse=1 drives start and program writes throughout the run.
    task automatic run(input int n, input bit abuse);
        int          nc;
        int          c;
        int          idx;
        int          d0;
        logic [7:0]  r;
        logic [7:0]  a;
        logic [20:0] w;
        nc = (n > DEPTH) ? DEPTH : n;
        r  = m_result;
        for (int i = 0; i < nc; i++) begin
            w         = tb_mem[i];
            a         = w[20] ? r : w[15:8];
            exp_a[i]  = a;
            exp_b[i]  = w[7:0];
            exp_op[i] = w[19:16];
            if (w[19:16] == 4'd0)      r = a + w[7:0];
            else if (w[19:16] == 4'd1) r = a - w[7:0];
            else                       r = 8'h00;
        end
        exp_q.push_back(r);
        m_result = r;
        d0 = done_cnt;

        bus.start = 1'b1;
        bus.len   = n[4:0];
        tick();
        bus.start = 1'b0;
        check_eq("busy_after_start", 32'(bus.busy), 32'd1);

        c = 0;
        while (bus.done !== 1'b1 && c < 300) begin
            if ((c % (1 + LAT)) == 0 && (c / (1 + LAT)) < nc) begin
                idx = c / (1 + LAT);
                check_eq("issue_pc",     32'(bus.pc),         32'(idx));
                check_eq("issue_opcode", 32'(bus.alu_opcode), 32'(exp_op[idx]));
                check_eq("issue_a",      32'(bus.alu_a),      32'(exp_a[idx]));
                check_eq("issue_b",      32'(bus.alu_b),      32'(exp_b[idx]));
            end
            if (abuse) begin
                bus.start     = 1'b1;
                bus.len       = 5'd1;
                bus.prog_we   = 1'b1;
                bus.prog_addr = c[3:0];
                bus.prog_data = 21'h1ABCDE;
            end
            tick();
            c++;
        end
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
        check_eq("done_cycle", 32'(c), 32'(nc * (1 + LAT)));
        tick();
        check_eq("busy_after_done", 32'(bus.busy), 32'd0);
        check_eq("done_width",      32'(bus.done), 32'd0);
        tick();
        check_eq("done_count", 32'(done_cnt - d0), 32'd1);
        check_eq("idle_stays", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.start     = 1'b0;
        bus.len       = '0;
        m_result      = 8'h00;
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;

        // Reset asserted mid-clock: outputs must clear before any edge.
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_busy",   32'(bus.busy),       32'd0);
        check_eq("rst_done",   32'(bus.done),       32'd0);
        check_eq("rst_result", 32'(bus.result),     32'd0);
        check_eq("rst_pc",     32'(bus.pc),         32'd0);
        check_eq("rst_opcode", 32'(bus.alu_opcode), 32'd0);
        check_eq("rst_a",      32'(bus.alu_a),      32'd0);
        check_eq("rst_b",      32'(bus.alu_b),      32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single instruction 1+1.
        load_word(0, {1'b0, 4'h0, 8'h01, 8'h01});
        run(1, 1'b0);
        check_eq("single_result", 32'(bus.result), 32'h02);

        // Chained three-step program: 0x08, 0x12, 0x0E.
        load_word(0, {1'b0, 4'h0, 8'h05, 8'h03});
        load_word(1, {1'b1, 4'h0, 8'h00, 8'h0A});
        load_word(2, {1'b1, 4'h1, 8'h00, 8'h04});
        run(3, 1'b0);
        check_eq("chain_result", 32'(bus.result), 32'h0E);

        // Zero length leaves result untouched.
        run(0, 1'b0);
        check_eq("zero_len_result", 32'(bus.result), 32'h0E);

        // Chained 0xFF + 0x01 wraps to 0x00.
        load_word(0, {1'b0, 4'h0, 8'hFF, 8'h00});
        load_word(1, {1'b1, 4'h0, 8'h00, 8'h01});
        run(2, 1'b0);
        check_eq("wrap_result", 32'(bus.result), 32'h00);

        // Start and writes during a run are ignored; rerun shows memory intact.
        run(3, 1'b1);
        check_eq("abuse_result", 32'(bus.result), 32'hFC);
        run(3, 1'b0);
        check_eq("mem_intact_result", 32'(bus.result), 32'hFC);

        // Oversize length clamps to DEPTH.
        for (int i = 0; i < DEPTH; i++) begin
            load_word(i, {1'($urandom_range(0, 1)), 3'b000, 1'($urandom_range(0, 1)),
                          8'($urandom), 8'($urandom)});
        end
        run(20, 1'b0);

        // Reset in the WAIT of the second instruction, then relaunch.
        load_word(0, {1'b0, 4'h0, 8'h05, 8'h03});
        load_word(1, {1'b1, 4'h0, 8'h00, 8'h0A});
        load_word(2, {1'b1, 4'h1, 8'h00, 8'h04});
        bus.start = 1'b1;
        bus.len   = 5'd3;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check_eq("mid_pc", 32'(bus.pc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_busy",   32'(bus.busy),   32'd0);
        check_eq("abort_done",   32'(bus.done),   32'd0);
        check_eq("abort_result", 32'(bus.result), 32'd0);
        check_eq("abort_pc",     32'(bus.pc),     32'd0);
        check_eq("abort_a",      32'(bus.alu_a),  32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
        m_result = 8'h00;
        repeat (4) tick();
        check_eq("post_abort_idle", 32'(bus.busy), 32'd0);
        run(3, 1'b0);
        check_eq("relaunch_result", 32'(bus.result), 32'h00);

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
